// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control block: FSM encoding,
// write-back/memory-access codes and the per-stage control bundle.
package pipeline_ctrl_pkg;

    localparam int unsigned RF_AW  = 5;
    localparam int unsigned WSEL_W = 2;
    localparam int unsigned DMEM_W = 4;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

    localparam logic [WSEL_W-1:0] WD_SEL_MEM = 2'd2;
    localparam logic [DMEM_W-1:0] DMEM_NONE  = 4'd0;

    // Control pair driven into one inter-stage register.
    typedef struct packed {
        logic stall;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_mem_wait.sv
// Data-memory wait sequencer: holds the pipeline for MEM_WAIT cycles per access.
// Ports: clk, rst (async active-low), en (global enable), access (MEM access type),
//        mem_wait (combinational: MEM stage must wait this cycle).
module pipeline_mem_wait
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DMEM_W-1:0] access,
    output logic              mem_wait
);

    localparam logic [3:0] WCNT_LAST = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);

    logic [3:0] wcnt;
    logic       wait_done;

    assign mem_wait = (MEM_WAIT != 0) && en && (access != DMEM_NONE) && !wait_done;

    // wait_done lets the access through for one cycle, then clears once EX/MEM advances
    // so a following access waits again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt      <= 4'd0;
            wait_done <= 1'b0;
        end else if (en) begin
            if (mem_wait) begin
                if (wcnt == WCNT_LAST) begin
                    wcnt      <= 4'd0;
                    wait_done <= 1'b1;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end else begin
                wait_done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central 5-stage pipeline control: run/step/halt FSM, hazard priority
// (mem-wait > branch > load-use) and cycle/commit counters.
// Ports: run/step/halt_req debug control; ID/EX/MEM/WB hazard inputs;
//        global_en, pc_en, per-stage stall/flush (same-cycle), halted,
//        cycle_cnt, inst_cnt.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic [RF_AW-1:0]  id_rf_ra0,
    input  logic [RF_AW-1:0]  id_rf_ra1,
    input  logic [RF_AW-1:0]  ex_rf_wa,
    input  logic              ex_rf_we,
    input  logic [WSEL_W-1:0] ex_rf_wd_sel,
    input  logic              ex_br_taken,
    input  logic [DMEM_W-1:0] mem_dmem_access,
    input  logic              wb_commit,
    output logic              global_en,
    output logic              pc_en,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              ex_mem_stall,
    output logic              mem_wb_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mem_wb_flush,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt
);

    state_e      state, state_nxt;
    logic        mem_wait;
    logic        load_use;
    stage_ctrl_t if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_HALT;
        else      state <= state_nxt;
    end

    // Next-state logic; step pulses outside HALT fall through unused.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_HALT: begin
                if (run)       state_nxt = ST_RUN;
                else if (step) state_nxt = ST_STEP;
            end
            ST_RUN:  if (halt_req || !run)      state_nxt = ST_HALT;
            ST_STEP: if (halt_req || wb_commit) state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    assign global_en = (state != ST_HALT);
    assign halted    = (state == ST_HALT);

    pipeline_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
        .clk      (clk),
        .rst      (rst),
        .en       (global_en),
        .access   (mem_dmem_access),
        .mem_wait (mem_wait)
    );

    assign load_use = ex_rf_we && (ex_rf_wd_sel == WD_SEL_MEM) && (ex_rf_wa != 5'd0) &&
                      ((ex_rf_wa == id_rf_ra0) || (ex_rf_wa == id_rf_ra1));

    // Hazard priority mux; everything stays low while halted.
    always_comb begin
        pc_en    = 1'b0;
        if_id_c  = '0;
        id_ex_c  = '0;
        ex_mem_c = '0;
        mem_wb_c = '0;
        if (global_en) begin
            if (mem_wait) begin
                if_id_c.stall  = 1'b1;
                id_ex_c.stall  = 1'b1;
                ex_mem_c.stall = 1'b1;
                mem_wb_c.flush = 1'b1;
            end else if (ex_br_taken) begin
                pc_en         = 1'b1;
                if_id_c.flush = 1'b1;
                id_ex_c.flush = 1'b1;
            end else if (load_use) begin
                if_id_c.stall = 1'b1;
                id_ex_c.flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    assign {if_id_stall,  if_id_flush}  = if_id_c;
    assign {id_ex_stall,  id_ex_flush}  = id_ex_c;
    assign {ex_mem_stall, ex_mem_flush} = ex_mem_c;
    assign {mem_wb_stall, mem_wb_flush} = mem_wb_c;

    // Performance counters, wrapping naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (global_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (wb_commit) inst_cnt <= inst_cnt + CNT_W'(1);
        end
    end

endmodule
